// File: rtl/mmio_servo_hub.sv
// -----------------------------------------------------------------------------
// mmio_servo_hub
//
// Memory-mapped peripheral that places NUM_CH button-event channels and NUM_CH
// servo duty channels behind one 32-word register window on the data bus.
// Button presses are latched into sticky flags that clear when read. Servo
// targets are clamped on write, and each channel's current duty slews toward
// its target by STEP units per ramp tick (STEP == 0 snaps immediately).
//
// Register window (offset = addr - BASE_ADDR):
//   0 .. NUM_CH-1       TARGET[i]   read/write, clamped to [MIN_DUTY, MAX_DUTY]
//   8 .. 8+NUM_CH-1     SHORT_EV[i] read-clear
//   16 .. 16+NUM_CH-1   LONG_EV[i]  read-clear
//   24                  STATUS      read-only, {zero, busy}
//   25                  STEP        read/write, low 8 bits
//   anything else       reads 0, writes ignored
//
// Ports:
//   clock      system clock
//   reset      synchronous, active-low reset
//   addr       word address from the processor
//   wren       write enable
//   data_in    write data
//   data_out   read data, registered (one cycle after addr, aligned with RAM)
//   hit        registered: previous-cycle addr was inside the window
//   btn_short  short-press event inputs, one per channel
//   btn_long   long-press event inputs, one per channel
//   duty_out   current ramped duty, channel i at [i*DUTY_W +: DUTY_W]
//   busy       bit i set while current duty i differs from target i
// -----------------------------------------------------------------------------
module mmio_servo_hub #(
    parameter int          NUM_CH       = 3,
    parameter int          DUTY_W       = 10,
    parameter logic [11:0] BASE_ADDR    = 12'd32,
    parameter int          TICK_DIV     = 50000,
    parameter int          MIN_DUTY     = 50,
    parameter int          MAX_DUTY     = 250,
    parameter int          CENTER       = 150,
    parameter int          DEFAULT_STEP = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [11:0]              addr,
    input  logic                     wren,
    input  logic [31:0]              data_in,
    output logic [31:0]              data_out,
    output logic                     hit,
    input  logic [NUM_CH-1:0]        btn_short,
    input  logic [NUM_CH-1:0]        btn_long,
    output logic [NUM_CH*DUTY_W-1:0] duty_out,
    output logic [NUM_CH-1:0]        busy
);

    // Ramp arithmetic width: wide enough that cur + 255 never overflows and
    // cur - 255 stays representable as a negative signed value.
    localparam int RW    = DUTY_W + 9;
    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [4:0] OFF_SHORT  = 5'd8;
    localparam logic [4:0] OFF_LONG   = 5'd16;
    localparam logic [4:0] OFF_STATUS = 5'd24;
    localparam logic [4:0] OFF_STEP   = 5'd25;

    // -------------------------------------------------------------------------
    // Saturating helpers
    // -------------------------------------------------------------------------

    // Clamp a raw 32-bit write value into the legal target range. The compare
    // is done on the full unsigned word so large values clamp high instead of
    // wrapping after truncation.
    function automatic logic [DUTY_W-1:0] clamp_target(input logic [31:0] v);
        if (v < 32'(MIN_DUTY)) begin
            return DUTY_W'(MIN_DUTY);
        end else if (v > 32'(MAX_DUTY)) begin
            return DUTY_W'(MAX_DUTY);
        end else begin
            return v[DUTY_W-1:0];
        end
    endfunction

    // One ramp step of size s from c toward t, never passing t.
    function automatic logic [DUTY_W-1:0] ramp_next(
        input logic [DUTY_W-1:0] c,
        input logic [DUTY_W-1:0] t,
        input logic [7:0]        s
    );
        logic signed [RW-1:0] cw;
        logic signed [RW-1:0] tw;
        logic signed [RW-1:0] sw;
        logic signed [RW-1:0] up;
        logic signed [RW-1:0] dn;
        cw = $signed(RW'(c));
        tw = $signed(RW'(t));
        sw = $signed(RW'(s));
        up = cw + sw;
        dn = cw - sw;
        if (cw < tw) begin
            return (up > tw) ? t : up[DUTY_W-1:0];
        end else if (cw > tw) begin
            return (dn < tw) ? t : dn[DUTY_W-1:0];
        end else begin
            return c;
        end
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DUTY_W-1:0] tgt [NUM_CH];
    logic [DUTY_W-1:0] cur [NUM_CH];
    logic [7:0]        step;
    logic [NUM_CH-1:0] short_ev;
    logic [NUM_CH-1:0] long_ev;
    logic [CNT_W-1:0]  tick_cnt;
    logic [31:0]       rdata_p1;
    logic              hit_p1;

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    // Addresses below the base wrap to a large offset, so "upper offset bits
    // all zero" is an exact window test as long as the window fits in 12 bits.
    logic [11:0]       offset_w;
    logic [4:0]        offset;
    logic              in_win;
    logic              tick;
    logic [NUM_CH-1:0] busy_w;
    logic [NUM_CH-1:0] wr_tgt;
    logic [NUM_CH-1:0] rd_short;
    logic [NUM_CH-1:0] rd_long;
    logic              wr_step;
    logic [31:0]       rdata;

    assign offset_w = addr - BASE_ADDR;
    assign in_win   = (offset_w[11:5] == 7'd0);
    assign offset   = offset_w[4:0];
    assign tick     = (tick_cnt == CNT_W'(TICK_DIV - 1));
    assign wr_step  = in_win && wren && (offset == OFF_STEP);

    always_comb begin
        wr_tgt   = '0;
        rd_short = '0;
        rd_long  = '0;
        busy_w   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_tgt[i]   = in_win &&  wren && (offset == 5'(i));
            rd_short[i] = in_win && !wren && (offset == OFF_SHORT + 5'(i));
            rd_long[i]  = in_win && !wren && (offset == OFF_LONG + 5'(i));
            busy_w[i]   = (cur[i] != tgt[i]);
        end
    end

    // Read mux: values seen here are the pre-update register contents, so an
    // event read returns the flag before it clears.
    always_comb begin
        rdata = '0;
        if (in_win) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (offset == 5'(i)) begin
                    rdata[DUTY_W-1:0] = tgt[i];
                end
                if (offset == OFF_SHORT + 5'(i)) begin
                    rdata[0] = short_ev[i];
                end
                if (offset == OFF_LONG + 5'(i)) begin
                    rdata[0] = long_ev[i];
                end
            end
            if (offset == OFF_STATUS) begin
                rdata[NUM_CH-1:0] = busy_w;
            end
            if (offset == OFF_STEP) begin
                rdata[7:0] = step;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage p1: registered read data, events, tick counter, targets and ramp
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                tgt[i] <= DUTY_W'(CENTER);
                cur[i] <= DUTY_W'(CENTER);
            end
            step     <= 8'(DEFAULT_STEP);
            short_ev <= '0;
            long_ev  <= '0;
            tick_cnt <= '0;
            rdata_p1 <= '0;
            hit_p1   <= 1'b0;
        end else begin
            rdata_p1 <= rdata;
            hit_p1   <= in_win;
            tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);

            // A new press arriving with the read keeps the flag set.
            short_ev <= btn_short | (short_ev & ~rd_short);
            long_ev  <= btn_long  | (long_ev  & ~rd_long);

            if (wr_step) begin
                step <= data_in[7:0];
            end

            // The ramp reads the target register before this edge's write,
            // so a write coinciding with a tick takes effect next tick.
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_tgt[i]) begin
                    tgt[i] <= clamp_target(data_in);
                end
                if (step == 8'd0) begin
                    cur[i] <= tgt[i];
                end else if (tick) begin
                    cur[i] <= ramp_next(cur[i], tgt[i], step);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign data_out = rdata_p1;
    assign hit      = hit_p1;
    assign busy     = busy_w;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_duty
        assign duty_out[g*DUTY_W +: DUTY_W] = cur[g];
    end

endmodule
